// File: rtl/wrapper_paralelo_serial.sv
// Parallel-to-serial transmitter for the SD host data/command path.
// Captures an n-bit frame on a load handshake and shifts it out MSB-first,
// one bit per enabled clock edge. The line idles high.
module wrapper_paralelo_serial #(
    parameter int unsigned n = 128
) (
    input  logic         sd_clock,
    input  logic         reset,
    input  logic [n-1:0] parallel,
    input  logic         load,
    input  logic         enable,
    output logic         serial,
    output logic         ready,
    output logic         busy,
    output logic         complete
);

    localparam int unsigned CountW = $clog2(n + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e              state_q, state_d;
    logic [n-1:0]        shreg_q, shreg_d;
    logic [CountW-1:0]   count_q, count_d;
    logic                serial_q, serial_d;

    // State, shift register, bit counter and line register; reset overrides all.
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            count_q  <= '0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            count_q  <= count_d;
            serial_q <= serial_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        count_d  = count_q;
        serial_d = serial_q;
        unique case (state_q)
            StIdle: begin
                serial_d = 1'b1;
                if (load) begin
                    shreg_d = parallel;
                    count_d = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                // With enable low everything holds, so the line keeps its last bit.
                if (enable) begin
                    serial_d = shreg_q[n-1];
                    shreg_d  = {shreg_q[n-2:0], 1'b0};
                    if (count_q == CountW'(n - 1)) begin
                        count_d = '0;
                        state_d = StDone;
                    end else begin
                        count_d = count_q + CountW'(1);
                    end
                end
            end
            StDone: begin
                // Single cycle; the line still shows bit 0 until this edge.
                serial_d = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                serial_d = 1'b1;
                state_d  = StIdle;
            end
        endcase
    end

    // Status outputs decoded from the state register only.
    always_comb begin
        serial   = serial_q;
        ready    = (state_q == StIdle);
        busy     = (state_q == StShift) || (state_q == StDone);
        complete = (state_q == StDone);
    end

endmodule

// File: tb/tb_wrapper_paralelo_serial.sv
// Self-checking bench for wrapper_paralelo_serial: table-driven n=8 sequences
// plus hand-written n=128 reset-abort and loopback sequences.
module tb_wrapper_paralelo_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    // n = 8 instance
    logic [7:0]   par8;
    logic         ld8, en8;
    logic         s8, r8, b8, c8;
    // n = 128 instance
    logic [127:0] par128;
    logic         ld128, en128;
    logic         s128, r128, b128, c128;

    int n_checks = 0;
    int n_fail   = 0;

    wrapper_paralelo_serial #(.n(8)) u_dut8 (
        .sd_clock (clk),
        .reset    (reset),
        .parallel (par8),
        .load     (ld8),
        .enable   (en8),
        .serial   (s8),
        .ready    (r8),
        .busy     (b8),
        .complete (c8)
    );

    wrapper_paralelo_serial #(.n(128)) u_dut128 (
        .sd_clock (clk),
        .reset    (reset),
        .parallel (par128),
        .load     (ld128),
        .enable   (en128),
        .serial   (s128),
        .ready    (r128),
        .busy     (b128),
        .complete (c128)
    );

    typedef struct packed {
        logic       ld;
        logic       en;
        logic [7:0] par;
        logic       s;
        logic       r;
        logic       b;
        logic       c;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic ld, input logic en, input logic [7:0] par,
                                input logic s, input logic r, input logic b, input logic c);
        vec_t v;
        v.ld = ld; v.en = en; v.par = par;
        v.s = s; v.r = r; v.b = b; v.c = c;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Row-driven check of the n=8 instance: drive row, clock, compare after the edge.
    task automatic run_table();
        foreach (vq[i]) begin
            ld8  = vq[i].ld;
            en8  = vq[i].en;
            par8 = vq[i].par;
            tick();
            chk($sformatf("row%0d serial", i),   {127'd0, s8}, {127'd0, vq[i].s});
            chk($sformatf("row%0d ready", i),    {127'd0, r8}, {127'd0, vq[i].r});
            chk($sformatf("row%0d busy", i),     {127'd0, b8}, {127'd0, vq[i].b});
            chk($sformatf("row%0d complete", i), {127'd0, c8}, {127'd0, vq[i].c});
        end
    endtask

    // Loopback: a receiver enabled one cycle after the transmit enable is
    // equivalent to sampling the line right after each enabled edge.
    task automatic send128(input logic [127:0] frame, input bit gaps, input string tag);
        logic [127:0] rx;
        int           k;
        bit           en;
        bit           done;
        rx    = '0;
        k     = 0;
        done  = 0;
        ld128 = 1'b1;
        par128 = frame;
        en128 = 1'($urandom_range(0, 1));
        tick();
        chk({tag, " started"}, {127'd0, b128}, 128'd1);
        ld128  = 1'b0;
        par128 = ~frame;
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            en    = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            en128 = en;
            tick();
            if (en) begin
                rx = {rx[126:0], s128};
                k++;
                if (k == 128) begin
                    done = 1;
                    chk({tag, " complete"}, {127'd0, c128}, 128'd1);
                    chk({tag, " frame"}, rx, frame);
                end
            end
        end
        if (!done) chk({tag, " timeout"}, 128'd0, 128'd1);
        en128 = $urandom_range(0, 1);
        tick();
        chk({tag, " idle ready"}, {127'd0, r128}, 128'd1);
        chk({tag, " idle serial"}, {127'd0, s128}, 128'd1);
    endtask

    initial begin
        logic [127:0] fr;
        bit           saw_c;
        reset = 1'b1;
        ld8 = 1'b1;  en8 = 1'b1;  par8 = 8'($urandom);
        ld128 = 1'b1; en128 = 1'b1; par128 = {$urandom, $urandom, $urandom, $urandom};

        // Reset held for two edges with load asserted.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst serial8", {127'd0, s8}, 128'd1);
            chk("rst ready8", {127'd0, r8}, 128'd1);
            chk("rst busy8", {127'd0, b8}, 128'd0);
            chk("rst complete8", {127'd0, c8}, 128'd0);
            chk("rst serial128", {127'd0, s128}, 128'd1);
            chk("rst ready128", {127'd0, r128}, 128'd1);
        end
        reset = 1'b0; ld8 = 1'b0; ld128 = 1'b0;
        tick();
        chk("post-rst ready8", {127'd0, r8}, 128'd1);
        chk("post-rst busy128", {127'd0, b128}, 128'd0);

        // Frame A5, enable high: bits 1,0,1,0,0,1,0,1.
        add(1, 1, 8'hA5, 1, 0, 1, 0);
        add(0, 1, 8'h00, 1, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 1, 8'h00, 1, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 1, 8'h00, 1, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 1, 8'h00, 1, 0, 1, 1);
        add(0, 1, 8'h00, 1, 1, 0, 0);
        // Frame 81 with enable low at E3 and E6; complete after E10.
        add(1, 0, 8'h81, 1, 0, 1, 0);
        add(0, 1, 8'h00, 1, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 0, 8'h00, 0, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 0, 8'h00, 0, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 1, 8'h00, 1, 0, 1, 1);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        // Frame F0 with 0F loads during SHIFT (E3) and DONE (E9), then 0F accepted at E10.
        add(1, 1, 8'hF0, 1, 0, 1, 0);
        add(0, 1, 8'h00, 1, 0, 1, 0);
        add(0, 1, 8'h00, 1, 0, 1, 0);
        add(1, 1, 8'h0F, 1, 0, 1, 0);
        add(0, 1, 8'h0F, 1, 0, 1, 0);
        add(0, 1, 8'h0F, 0, 0, 1, 0);
        add(0, 1, 8'h0F, 0, 0, 1, 0);
        add(0, 1, 8'h0F, 0, 0, 1, 0);
        add(0, 1, 8'h0F, 0, 0, 1, 1);
        add(1, 0, 8'h0F, 1, 1, 0, 0);
        add(1, 1, 8'h0F, 1, 0, 1, 0);
        add(0, 1, 8'hAA, 0, 0, 1, 0);
        add(0, 1, 8'hAA, 0, 0, 1, 0);
        add(0, 1, 8'hAA, 0, 0, 1, 0);
        add(0, 1, 8'hAA, 0, 0, 1, 0);
        add(0, 1, 8'hAA, 1, 0, 1, 0);
        add(0, 1, 8'hAA, 1, 0, 1, 0);
        add(0, 1, 8'hAA, 1, 0, 1, 0);
        add(0, 1, 8'hAA, 1, 0, 1, 1);
        add(0, 1, 8'hAA, 1, 1, 0, 0);
        run_table();
        ld8 = 1'b0; en8 = 1'b0;

        // Reset after E40 of a random 128-bit frame, with load asserted alongside.
        fr    = {$urandom, $urandom, $urandom, $urandom};
        ld128 = 1'b1; par128 = fr; en128 = 1'b1;
        tick();
        ld128 = 1'b0;
        saw_c = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (c128) saw_c = 1;
            if (i == 40) chk("E40 bit", {127'd0, s128}, {127'd0, fr[88]});
        end
        reset = 1'b1; ld128 = 1'b1;
        tick();
        if (c128) saw_c = 1;
        chk("abort serial", {127'd0, s128}, 128'd1);
        chk("abort ready", {127'd0, r128}, 128'd1);
        chk("abort busy", {127'd0, b128}, 128'd0);
        reset = 1'b0; ld128 = 1'b0;
        tick();
        if (c128) saw_c = 1;
        chk("abort load dropped", {127'd0, r128}, 128'd1);
        chk("abort no complete", {127'd0, saw_c}, 128'd0);
        send128({$urandom, $urandom, $urandom, $urandom}, 1'b0, "post-abort");

        // Loopback with random enable gaps.
        for (int f = 0; f < 50; f++) begin
            send128({$urandom, $urandom, $urandom, $urandom}, 1'b1, $sformatf("loop%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
